// File: rtl/onewire_txn_ctrl.sv
// 1-wire transaction sequencer: splits a host command into reset/write/read bit ops, bytes LSB first.
// Optional Dallas CRC-8 over read bits when ONEWIRE_CRC8_EN is defined; otherwise crc_ok_o is tied high.
module onewire_txn_ctrl #(
  parameter int LEN_W   = 4,
  parameter int TIMEOUT = 100000
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic             cmd_reset_i,
  input  logic [LEN_W-1:0] cmd_wlen_i,
  input  logic [LEN_W-1:0] cmd_rlen_i,
  input  logic             wr_valid_i,
  output logic             wr_ready_o,
  input  logic [7:0]       wr_data_i,
  output logic             rd_valid_o,
  input  logic             rd_ready_i,
  output logic [7:0]       rd_data_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [1:0]       status_o,
  output logic             crc_ok_o,
  output logic             bit_req_o,
  output logic [1:0]       bit_op_o,
  output logic             bit_wdata_o,
  input  logic             bit_done_i,
  input  logic             bit_rdata_i,
  input  logic             bit_presence_i
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_RST, S_WLOAD, S_WBIT, S_RBIT, S_RSEND, S_FIN
  } state_t;

  state_t           state_q, state_d;
  logic             rdy_en_q;
  logic [LEN_W-1:0] wlen_q, wlen_d;
  logic [LEN_W-1:0] rlen_q, rlen_d;
  logic [7:0]       byte_q, byte_d;
  logic [2:0]       bcnt_q, bcnt_d;
  logic             pend_q, pend_d;
  logic [TW-1:0]    wdog_q, wdog_d;
  logic [1:0]       status_q, status_d;
  logic             op_done;
  logic             bit_state;

`ifdef ONEWIRE_CRC8_EN
  logic [7:0] crc_q, crc_d;
  logic       crc_ok_q, crc_ok_d;
`endif

  assign op_done   = pend_q && bit_done_i;
  assign bit_state = (state_q == S_RST) || (state_q == S_WBIT) || (state_q == S_RBIT);

  always_comb begin
    state_d     = state_q;
    wlen_d      = wlen_q;
    rlen_d      = rlen_q;
    byte_d      = byte_q;
    bcnt_d      = bcnt_q;
    pend_d      = pend_q;
    wdog_d      = wdog_q;
    status_d    = status_q;
    cmd_ready_o = 1'b0;
    wr_ready_o  = 1'b0;
    rd_valid_o  = 1'b0;
    rd_data_o   = 8'h00;
    done_o      = 1'b0;
    bit_req_o   = 1'b0;
    bit_op_o    = 2'b00;
    bit_wdata_o = 1'b0;
`ifdef ONEWIRE_CRC8_EN
    crc_d       = crc_q;
    crc_ok_d    = crc_ok_q;
`endif

    case (state_q)
      S_IDLE: begin
        cmd_ready_o = rdy_en_q;
        if (cmd_valid_i && rdy_en_q) begin
          wlen_d   = cmd_wlen_i;
          rlen_d   = cmd_rlen_i;
          status_d = 2'b00;
          bcnt_d   = 3'd0;
`ifdef ONEWIRE_CRC8_EN
          crc_d    = 8'h00;
`endif
          if (cmd_reset_i)              state_d = S_RST;
          else if (cmd_wlen_i != '0)    state_d = S_WLOAD;
          else if (cmd_rlen_i != '0)    state_d = S_RBIT;
          else                          state_d = S_FIN;
        end
      end
      S_RST: begin
        if (op_done) begin
          if (!bit_presence_i) begin
            status_d = 2'b01;
            state_d  = S_FIN;
          end else if (wlen_q != '0) state_d = S_WLOAD;
          else if (rlen_q != '0)     state_d = S_RBIT;
          else                       state_d = S_FIN;
        end
      end
      S_WLOAD: begin
        if (wr_valid_i) begin
          wr_ready_o = 1'b1;
          byte_d     = wr_data_i;
          bcnt_d     = 3'd0;
          state_d    = S_WBIT;
        end
      end
      S_WBIT: begin
        bit_op_o    = 2'b01;
        bit_wdata_o = byte_q[0];
        if (op_done) begin
          byte_d = {1'b0, byte_q[7:1]};
          bcnt_d = bcnt_q + 3'd1;
          if (bcnt_q == 3'd7) begin
            wlen_d = wlen_q - LEN_W'(1);
            if (wlen_q != LEN_W'(1)) state_d = S_WLOAD;
            else if (rlen_q != '0)   state_d = S_RBIT;
            else                     state_d = S_FIN;
          end
        end
      end
      S_RBIT: begin
        bit_op_o = 2'b10;
        if (op_done) begin
          byte_d = {bit_rdata_i, byte_q[7:1]};
          bcnt_d = bcnt_q + 3'd1;
`ifdef ONEWIRE_CRC8_EN
          crc_d  = (crc_q[0] ^ bit_rdata_i) ? ({1'b0, crc_q[7:1]} ^ 8'h8C) : {1'b0, crc_q[7:1]};
`endif
          if (bcnt_q == 3'd7) begin
            rlen_d  = rlen_q - LEN_W'(1);
            state_d = S_RSEND;
          end
        end
      end
      S_RSEND: begin
        rd_valid_o = 1'b1;
        rd_data_o  = byte_q;
        if (rd_ready_i) state_d = (rlen_q != '0) ? S_RBIT : S_FIN;
      end
      S_FIN: begin
        done_o  = 1'b1;
        pend_d  = 1'b0;
        state_d = S_IDLE;
`ifdef ONEWIRE_CRC8_EN
        crc_ok_d = (crc_q == 8'h00);
`endif
      end
      default: state_d = S_IDLE;
    endcase

    // One op in flight; wdog_q holds the number of cycles since its bit_req.
    if (bit_state) begin
      if (!pend_q) begin
        bit_req_o = 1'b1;
        pend_d    = 1'b1;
        wdog_d    = TW'(1);
      end else if (bit_done_i) begin
        pend_d = 1'b0;
      end else if (wdog_q == TW'(TIMEOUT - 1)) begin
        pend_d   = 1'b0;
        status_d = 2'b10;
        state_d  = S_FIN;
      end else begin
        wdog_d = wdog_q + TW'(1);
      end
    end
  end

  assign busy_o   = (state_q != S_IDLE) && (state_q != S_FIN);
  assign status_o = status_q;

`ifdef ONEWIRE_CRC8_EN
  assign crc_ok_o = crc_ok_q;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      crc_q    <= 8'h00;
      crc_ok_q <= 1'b0;
    end else begin
      crc_q    <= crc_d;
      crc_ok_q <= crc_ok_d;
    end
  end
`else
  assign crc_ok_o = 1'b1;
`endif

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q  <= S_IDLE;
      rdy_en_q <= 1'b0;
      wlen_q   <= '0;
      rlen_q   <= '0;
      byte_q   <= 8'h00;
      bcnt_q   <= 3'd0;
      pend_q   <= 1'b0;
      wdog_q   <= '0;
      status_q <= 2'b00;
    end else begin
      state_q  <= state_d;
      rdy_en_q <= 1'b1;
      wlen_q   <= wlen_d;
      rlen_q   <= rlen_d;
      byte_q   <= byte_d;
      bcnt_q   <= bcnt_d;
      pend_q   <= pend_d;
      wdog_q   <= wdog_d;
      status_q <= status_d;
    end
  end

endmodule

// File: tb/tb_onewire_txn_ctrl.sv
// Scoreboard bench for onewire_txn_ctrl: modelled bit engine, host writer/reader, done monitor.
module tb_onewire_txn_ctrl;
  localparam int LEN_W = 4;
  localparam int TO    = 16;
`ifdef ONEWIRE_CRC8_EN
  localparam bit CRC_EN = 1'b1;
`else
  localparam bit CRC_EN = 1'b0;
`endif

  logic             clk_i = 1'b0;
  logic             reset_ni;
  logic             cmd_valid_i, cmd_ready_o, cmd_reset_i;
  logic [LEN_W-1:0] cmd_wlen_i, cmd_rlen_i;
  logic             wr_valid_i, wr_ready_o;
  logic [7:0]       wr_data_i;
  logic             rd_valid_o, rd_ready_i;
  logic [7:0]       rd_data_o;
  logic             busy_o, done_o, crc_ok_o;
  logic [1:0]       status_o;
  logic             bit_req_o, bit_wdata_o, bit_done_i, bit_rdata_i, bit_presence_i;
  logic [1:0]       bit_op_o;

  always #5 clk_i = ~clk_i;

  onewire_txn_ctrl #(.LEN_W(LEN_W), .TIMEOUT(TO)) dut (
    .clk_i(clk_i), .reset_ni(reset_ni),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_reset_i(cmd_reset_i),
    .cmd_wlen_i(cmd_wlen_i), .cmd_rlen_i(cmd_rlen_i),
    .wr_valid_i(wr_valid_i), .wr_ready_o(wr_ready_o), .wr_data_i(wr_data_i),
    .rd_valid_o(rd_valid_o), .rd_ready_i(rd_ready_i), .rd_data_o(rd_data_o),
    .busy_o(busy_o), .done_o(done_o), .status_o(status_o), .crc_ok_o(crc_ok_o),
    .bit_req_o(bit_req_o), .bit_op_o(bit_op_o), .bit_wdata_o(bit_wdata_o),
    .bit_done_i(bit_done_i), .bit_rdata_i(bit_rdata_i), .bit_presence_i(bit_presence_i)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [2:0] exp_op[$];
  logic       rbits[$];
  logic [7:0] exp_rd[$];
  logic [7:0] wq[$];
  logic [7:0] rom[8];

  int         cyc = 0;
  logic [1:0] exp_status = 2'b00;
  logic       exp_crc = 1'b1;
  logic [7:0] crc_m = 8'h00;
  logic       eng_presence = 1'b1;
  logic       eng_silent = 1'b0;
  int         rd_stall = 0;
  int         ndone = 0, done_cyc = 0, req_cyc = 0, acc_cyc = 0;
  int         nops = 0, wr_pulses = 0, stall_viol = 0;

  always @(posedge clk_i) cyc <= cyc + 1;

  function automatic logic [7:0] crc_bit(input logic [7:0] c, input logic b);
    logic fb;
    fb = c[0] ^ b;
    return fb ? ((c >> 1) ^ 8'h8C) : (c >> 1);
  endfunction

  task automatic prep(input logic [1:0] st, input logic pres);
    exp_status   = st;
    eng_presence = pres;
    crc_m        = 8'h00;
  endtask

  task automatic push_rst_op();
    exp_op.push_back(3'b000);
  endtask

  task automatic push_wr(input logic [7:0] b);
    wq.push_back(b);
    for (int i = 0; i < 8; i++) exp_op.push_back({2'b01, b[i]});
  endtask

  task automatic push_rd(input logic [7:0] b);
    exp_rd.push_back(b);
    for (int i = 0; i < 8; i++) begin
      rbits.push_back(b[i]);
      exp_op.push_back(3'b100);
      crc_m = crc_bit(crc_m, b[i]);
    end
  endtask

  task automatic check_zero(input string tag);
    chk(tag, 32'({cmd_ready_o, wr_ready_o, rd_valid_o, rd_data_o, busy_o, done_o,
                  status_o, bit_req_o, bit_op_o, bit_wdata_o}), 32'h0);
    chk({tag, "_crc"}, 32'(crc_ok_o), CRC_EN ? 32'h0 : 32'h1);
  endtask

  task automatic send_cmd(input logic r, input logic [LEN_W-1:0] wl, input logic [LEN_W-1:0] rl);
    int n;
    n = 0;
    @(negedge clk_i);
    while (!cmd_ready_o && n < 200) begin
      @(negedge clk_i);
      n++;
    end
    chk("cmd_rdy_wait", 32'(cmd_ready_o), 32'h1);
    cmd_reset_i = r;
    cmd_wlen_i  = wl;
    cmd_rlen_i  = rl;
    cmd_valid_i = 1'b1;
    acc_cyc     = cyc;
    @(posedge clk_i);
    #1;
    cmd_valid_i = 1'b0;
    chk("rdy_drop", 32'(cmd_ready_o), 32'h0);
  endtask

  task automatic wait_done(input int budget);
    int start, n;
    exp_crc = CRC_EN ? (crc_m == 8'h00) : 1'b1;
    start = ndone;
    n = 0;
    while (ndone == start && n < budget) begin
      @(negedge clk_i);
      n++;
    end
    chk("done_seen", 32'(ndone != start), 32'h1);
    chk("ops_left", 32'(exp_op.size()), 32'h0);
    chk("rd_left", 32'(exp_rd.size()), 32'h0);
  endtask

  // Bit engine: replies eng-delay cycles after each bit_req unless silenced.
  initial begin
    bit_done_i = 1'b0; bit_rdata_i = 1'b0; bit_presence_i = 1'b0;
    forever begin
      @(posedge clk_i);
      #1;
      bit_done_i = 1'b0; bit_rdata_i = 1'b0; bit_presence_i = 1'b0;
      if (reset_ni && bit_req_o) begin
        logic aborted;
        req_cyc = cyc;
        if (exp_op.size() == 0) chk("op_unexpected", 32'({bit_op_o, bit_wdata_o}), 32'h7);
        else chk("bit_op", 32'({bit_op_o, bit_wdata_o}), 32'(exp_op.pop_front()));
        if (!eng_silent) begin
          aborted = 1'b0;
          repeat (2) begin
            @(posedge clk_i);
            #1;
            if (!reset_ni) aborted = 1'b1;
          end
          if (!aborted) begin
            bit_rdata_i    = (bit_op_o == 2'b10 && rbits.size() > 0) ? rbits.pop_front() : 1'b0;
            bit_presence_i = eng_presence;
            bit_done_i     = 1'b1;
            nops++;
          end
        end
      end
    end
  end

  // Host write source.
  initial begin
    logic took;
    wr_valid_i = 1'b0; wr_data_i = 8'h00;
    forever begin
      @(negedge clk_i);
      took = wr_ready_o && reset_ni;
      @(posedge clk_i);
      #1;
      if (took && wq.size() > 0) begin
        void'(wq.pop_front());
        wr_pulses++;
      end
      wr_valid_i = wq.size() > 0;
      wr_data_i  = (wq.size() > 0) ? wq[0] : 8'h00;
    end
  end

  // Host read sink with programmable stall.
  initial begin
    int st;
    st = 0;
    rd_ready_i = 1'b0;
    forever begin
      @(negedge clk_i);
      if (bit_req_o && rd_valid_o) stall_viol++;
      if (!reset_ni) begin
        rd_ready_i = 1'b0;
        st = 0;
      end else if (rd_ready_i) begin
        rd_ready_i = 1'b0;
        chk("rdv_drop", 32'(rd_valid_o), 32'h0);
      end else if (rd_valid_o) begin
        if (exp_rd.size() == 0) chk("rd_unexpected", 32'(rd_data_o), 32'h100);
        else chk("rd_data", 32'(rd_data_o), 32'(exp_rd[0]));
        if (st < rd_stall) st++;
        else begin
          st = 0;
          rd_ready_i = 1'b1;
          if (exp_rd.size() > 0) void'(exp_rd.pop_front());
        end
      end
    end
  end

  // Done monitor.
  initial begin
    forever begin
      @(negedge clk_i);
      if (done_o) begin
        ndone++;
        done_cyc = cyc;
        chk("status", 32'(status_o), 32'(exp_status));
        chk("busy_at_done", 32'(busy_o), 32'h0);
        chk("crc_ok", 32'(crc_ok_o), 32'(exp_crc));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    int w0, sv, n0, d0, n;
    rom = '{8'h02, 8'h1C, 8'hB8, 8'h01, 8'h00, 8'h00, 8'h00, 8'hA2};
    reset_ni = 1'b0;
    cmd_valid_i = 1'b0; cmd_reset_i = 1'b0; cmd_wlen_i = '0; cmd_rlen_i = '0;
    repeat (2) @(negedge clk_i);
    check_zero("rst_state");
    reset_ni = 1'b1;
    #1 chk("rdy_at_release", 32'(cmd_ready_o), 32'h0);
    @(negedge clk_i);
    chk("rdy_after_release", 32'(cmd_ready_o), 32'h1);

    // Reset + one write byte, presence seen.
    prep(2'b00, 1'b1);
    push_rst_op();
    push_wr(8'hCC);
    w0 = wr_pulses;
    send_cmd(1'b1, 4'd1, 4'd0);
    chk("busy", 32'(busy_o), 32'h1);
    wait_done(400);
    chk("wr_pulses", 32'(wr_pulses - w0), 32'h1);

    // Same command, no presence: no write ops, byte never consumed.
    prep(2'b01, 1'b0);
    push_rst_op();
    wq.push_back(8'hCC);
    w0 = wr_pulses;
    send_cmd(1'b1, 4'd1, 4'd0);
    wait_done(400);
    chk("wr_no_pulse", 32'(wr_pulses - w0), 32'h0);
    wq.delete();

    // Two read bytes with host stalling.
    prep(2'b00, 1'b1);
    rd_stall = 5;
    sv = stall_viol;
    push_rd(8'hAA);
    push_rd(8'h55);
    send_cmd(1'b0, 4'd0, 4'd2);
    wait_done(800);
    chk("no_req_in_stall", 32'(stall_viol - sv), 32'h0);
    rd_stall = 0;

    // Silent engine: watchdog abort.
    prep(2'b10, 1'b1);
    eng_silent = 1'b1;
    push_rst_op();
    send_cmd(1'b1, 4'd0, 4'd0);
    wait_done(100);
    chk("timeout_latency", 32'(done_cyc - req_cyc), 32'(TO));
    eng_silent = 1'b0;

    // Empty command completes one cycle after accept.
    prep(2'b00, 1'b1);
    send_cmd(1'b0, 4'd0, 4'd0);
    wait_done(10);
    chk("empty_latency", 32'(done_cyc - acc_cyc), 32'h1);

    // Reset asserted after the third write bit.
    prep(2'b00, 1'b1);
    push_wr(8'hAA);
    push_wr(8'hBB);
    n0 = nops;
    d0 = ndone;
    send_cmd(1'b0, 4'd2, 4'd0);
    n = 0;
    while (nops - n0 < 3 && n < 300) begin
      @(negedge clk_i);
      n++;
    end
    chk("third_bit_seen", 32'(nops - n0 >= 3), 32'h1);
    reset_ni = 1'b0;
    #1 check_zero("mid_reset");
    exp_op.delete(); wq.delete(); rbits.delete(); exp_rd.delete();
    repeat (3) @(negedge clk_i);
    reset_ni = 1'b1;
    #1 chk("rdy_at_release2", 32'(cmd_ready_o), 32'h0);
    @(negedge clk_i);
    chk("rdy_after_release2", 32'(cmd_ready_o), 32'h1);
    chk("no_done_on_abort", 32'(ndone - d0), 32'h0);

    prep(2'b00, 1'b1);
    push_rst_op();
    push_wr(8'h3C);
    push_rd(8'h96);
    send_cmd(1'b1, 4'd1, 4'd1);
    wait_done(600);

    // ROM-ID read: CRC residue zero, then with one corrupted bit.
    prep(2'b00, 1'b1);
    for (int i = 0; i < 8; i++) push_rd(rom[i]);
    send_cmd(1'b0, 4'd0, 4'd8);
    wait_done(1500);
    prep(2'b00, 1'b1);
    for (int i = 0; i < 8; i++) push_rd((i == 7) ? (rom[i] ^ 8'h01) : rom[i]);
    send_cmd(1'b0, 4'd0, 4'd8);
    wait_done(1500);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
